riscv_lsu: RTL

- Load/store unit between the processor core's data-memory port and the data memory. Sits directly downstream of the core inside riscv_unit.
- Converts core byte/half/word requests into word-addressed memory requests with byte enables, and aligns/extends load data.
- Generates the core's stall signal. With a single-cycle memory, stall is high for exactly one cycle per access; with a slow memory, stall is held until the memory is ready.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/lsu_load_align.sv | 24 ++
 rtl/riscv_lsu.sv | 90 +++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared load/store size encodings and LSU state type.
//   LDST_*      : funct3 size codes seen on core_size_i
//   lsu_state_t : LSU FSM state (IDLE, WAIT)
package riscv_pkg;
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;
    typedef enum logic {IDLE, WAIT} lsu_state_t;
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half of a read word and extends it.
//   rd_i   : memory read word
//   off_i  : byte offset of the access within the word
//   size_i : funct3 size code
//   res_o  : 32-bit sign/zero extended load result
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rd_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  size_i,
    output logic [31:0] res_o
);
    logic [31:0] w_sh;
    logic [15:0] w_h;
    assign w_sh = rd_i >> {off_i, 3'b000};
    assign w_h  = off_i[1] ? rd_i[31:16] : rd_i[15:15 - 15];
    always_comb begin
        res_o = (size_i == LDST_B)  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                (size_i == LDST_BU) ? {24'd0, w_sh[7:0]} :
                (size_i == LDST_H)  ? {{16{w_h[15]}}, w_h} :
                (size_i == LDST_HU) ? {16'd0, w_h} : rd_i;
    end
endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core data port and a word-addressed data memory.
//   clk_i/rst_i      : clock, asynchronous active-low reset
//   core_*           : core request (req/we/size/addr/wd), load data, stall and error pulse
//   mem_*            : memory request with byte enables, replicated store data, read data, ready
//   TIMEOUT          : WAIT cycles before an access is aborted with an error (0 = never)
module riscv_lsu
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    lsu_state_t  r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_off;
    logic        w_illegal, w_misal, w_bad, w_start, w_done, w_tmo, w_wait;
    logic [31:0] w_ld;
    assign w_wait    = (r_state == WAIT);
    assign w_illegal = (core_size_i == 3'd3) || (core_size_i[2:1] == 2'b11);
    assign w_misal   = (((core_size_i == LDST_H) || (core_size_i == LDST_HU)) && core_addr_i[0]) ||
                       ((core_size_i == LDST_W) && (core_addr_i[1:0] != 2'b00));
    assign w_bad     = core_req_i && (w_illegal || w_misal);
    assign w_start   = !w_wait && core_req_i && !w_bad;
    assign w_done    = w_wait && mem_ready_i;
    assign w_tmo     = (TIMEOUT != 0) && w_wait && !mem_ready_i && (r_cnt == CW'(TIMEOUT));
    lsu_load_align u_align (
        .rd_i   (mem_rd_i),
        .off_i  (r_off),
        .size_i (r_size),
        .res_o  (w_ld)
    );
    always_comb begin
        w_next = r_state;
        if (w_start)
            w_next = WAIT;
        else if (w_done || w_tmo)
            w_next = IDLE;
    end
    // Outputs are gated by rst_i so an in-flight request drops the instant reset asserts.
    always_comb begin
        mem_req_o    = rst_i && (w_start || (w_wait && !w_tmo));
        core_stall_o = rst_i && (w_start || (w_wait && !mem_ready_i && !w_tmo));
        core_err_o   = rst_i && ((!w_wait && w_bad) || w_tmo);
        core_rd_o    = (rst_i && w_done) ? w_ld : 32'd0;
        mem_we_o     = core_we_i;
        mem_addr_o   = {core_addr_i[31:2], 2'b00};
        mem_be_o     = !core_we_i ? 4'b1111 :
                       (core_size_i[1:0] == 2'd0) ? (4'b0001 << core_addr_i[1:0]) :
                       (core_size_i[1:0] == 2'd1) ? (4'b0011 << {core_addr_i[1], 1'b0}) : 4'b1111;
        mem_wd_o     = (core_size_i[1:0] == 2'd0) ? {4{core_wd_i[7:0]}} :
                       (core_size_i[1:0] == 2'd1) ? {2{core_wd_i[15:0]}} : core_wd_i;
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_size  <= '0;
            r_off   <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_size <= core_size_i;
                r_off  <= core_addr_i[1:0];
            end
            // Counter saturates rather than wrapping so a disabled timeout never aliases.
            if (w_wait && !w_done && !w_tmo)
                r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end
endmodule
